// File: rtl/obi_pkg.sv
// Shared OBI bus types and widths, used by the slave arbiter and the interconnect.
package obi_pkg;

   localparam int unsigned OBI_AW  = 32;
   localparam int unsigned OBI_DW  = 32;
   localparam int unsigned OBI_BEW = 4;

   // Request attributes driven by a master while it holds req high.
   typedef struct packed {
      logic [OBI_AW-1:0]  addr;
      logic               we;
      logic [OBI_BEW-1:0] be;
      logic [OBI_DW-1:0]  wdata;
   } obi_req_t;

   // Response payload returned with rvalid.
   typedef struct packed {
      logic [OBI_DW-1:0] rdata;
   } obi_rsp_t;

endpackage

// File: rtl/obi_rsp_fifo.sv
// In-order FIFO holding the master index of every accepted, not yet answered
// transaction. The full flag already accounts for a pop in the same cycle.
// A push and a pop in the same cycle are both carried out.
module obi_rsp_fifo #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH)) && !pop_i;
   assign count_o = count_q;
   assign rdata_o = mem_q[rptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Pointer and occupancy next state; pointers wrap at DEPTH.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (do_push) begin
         wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      end
      if (do_pop) begin
         rptr_d = (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Control registers; reset empties the FIFO and discards stored IDs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage array write.
   always_ff @(posedge clk_i) begin
      // NOTE: storage is not reset; count_q guards every read, so stale entries are never used.
      if (do_push) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/obi_slave_arbiter.sv
// Shares one OBI slave port between NUM_MASTERS masters. It arbitrates requests and
// records the granted master of each transaction in an in-order ID FIFO. Responses
// are routed back to the issuing master.
// A waiting (ungranted) request is locked so its address stays stable until granted.
// Build option OBI_ARB_FIXED_PRIO_EN: lowest-index requester wins and the
// round-robin pointer is removed; default build is round-robin.
module obi_slave_arbiter
   import obi_pkg::*;
#(
   parameter int unsigned NUM_MASTERS     = 2,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [NUM_MASTERS-1:0]         m_req_i,
   output logic [NUM_MASTERS-1:0]         m_gnt_o,
   output logic [NUM_MASTERS-1:0]         m_rvalid_o,
   input  logic [NUM_MASTERS*OBI_AW-1:0]  m_addr_i,
   input  logic [NUM_MASTERS-1:0]         m_we_i,
   input  logic [NUM_MASTERS*OBI_BEW-1:0] m_be_i,
   input  logic [NUM_MASTERS*OBI_DW-1:0]  m_wdata_i,
   output logic [NUM_MASTERS*OBI_DW-1:0]  m_rdata_o,
   output logic                           s_req_o,
   input  logic                           s_gnt_i,
   input  logic                           s_rvalid_i,
   output logic [OBI_AW-1:0]              s_addr_o,
   output logic                           s_we_o,
   output logic [OBI_BEW-1:0]             s_be_o,
   output logic [OBI_DW-1:0]              s_wdata_o,
   input  logic [OBI_DW-1:0]              s_rdata_i,
   output logic                           err_o
);

   localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

   obi_req_t         m_bus [NUM_MASTERS];
   obi_req_t         sel_bus;
   logic [IDX_W-1:0] sel, cand, head_id;
   logic             found;
   logic             any_req, handshake;
   logic             fifo_full, fifo_empty, fifo_pop;
   logic [CNT_W-1:0] occupancy_unused;   // occupancy kept visible for debug only
   logic             lock_q, lock_d;
   logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
   logic             err_q, err_d;
`ifndef OBI_ARB_FIXED_PRIO_EN
   logic [IDX_W-1:0] ptr_q, ptr_d;
`endif

   // Unpack flat master buses; every response lane carries the slave read data.
   for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_lane
      assign m_bus[g] = '{addr:  m_addr_i[g*OBI_AW +: OBI_AW],
                          we:    m_we_i[g],
                          be:    m_be_i[g*OBI_BEW +: OBI_BEW],
                          wdata: m_wdata_i[g*OBI_DW +: OBI_DW]};
      assign m_rdata_o[g*OBI_DW +: OBI_DW] = s_rdata_i;
   end

   assign any_req   = |m_req_i;
   assign s_req_o   = any_req && !fifo_full;
   assign handshake = s_req_o && s_gnt_i;
   assign fifo_pop  = s_rvalid_i && !fifo_empty;
   assign err_o     = err_q;

   // Master selection: a locked (waiting) master keeps the slot, else priority search.
   always_comb begin
      sel   = '0;
      cand  = '0;
      found = 1'b0;
      if (lock_q && m_req_i[lock_idx_q]) begin
         sel = lock_idx_q;
      end else begin
         for (int k = 0; k < NUM_MASTERS; k++) begin
`ifdef OBI_ARB_FIXED_PRIO_EN
            cand = IDX_W'(k);
`else
            cand = IDX_W'((int'(ptr_q) + 1 + k) % NUM_MASTERS);
`endif
            if (!found && m_req_i[cand]) begin
               sel   = cand;
               found = 1'b1;
            end
         end
      end
   end

   // Slave request mux, zeroed whenever no request is presented.
   always_comb begin
      sel_bus   = m_bus[sel];
      s_addr_o  = s_req_o ? sel_bus.addr  : '0;
      s_we_o    = s_req_o ? sel_bus.we    : 1'b0;
      s_be_o    = s_req_o ? sel_bus.be    : '0;
      s_wdata_o = s_req_o ? sel_bus.wdata : '0;
   end

   // Grant to the selected master and response valid to the FIFO head.
   always_comb begin
      m_gnt_o    = '0;
      m_rvalid_o = '0;
      if (handshake) begin
         m_gnt_o[sel] = 1'b1;
      end
      if (fifo_pop) begin
         m_rvalid_o[head_id] = 1'b1;
      end
   end

   // Lock, pointer and sticky error next state.
   always_comb begin
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      err_d      = err_q || (s_rvalid_i && fifo_empty);
`ifndef OBI_ARB_FIXED_PRIO_EN
      ptr_d      = ptr_q;
`endif
      if (handshake) begin
         lock_d = 1'b0;
`ifndef OBI_ARB_FIXED_PRIO_EN
         ptr_d  = sel;
`endif
      end else if (s_req_o) begin
         lock_d     = 1'b1;
         lock_idx_d = sel;
      end else if (lock_q && !m_req_i[lock_idx_q]) begin
         lock_d = 1'b0;
      end
   end

   // Arbiter state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         err_q      <= 1'b0;
`ifndef OBI_ARB_FIXED_PRIO_EN
         ptr_q      <= IDX_W'(NUM_MASTERS - 1);
`endif
      end else begin
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         err_q      <= err_d;
`ifndef OBI_ARB_FIXED_PRIO_EN
         ptr_q      <= ptr_d;
`endif
      end
   end

   obi_rsp_fifo #(
      .WIDTH (IDX_W),
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (handshake),
      .pop_i   (fifo_pop),
      .wdata_i (sel),
      .rdata_o (head_id),
      .empty_o (fifo_empty),
      .full_o  (fifo_full),
      .count_o (occupancy_unused)
   );

endmodule

// File: tb/tb_obi_slave_arbiter.sv
// Self-checking bench for obi_slave_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// queue-based behavioural model.
module tb_obi_slave_arbiter;

   localparam int N    = 2;
   localparam int MAXO = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    m_req, m_gnt, m_rvalid, m_we;
   logic [N*32-1:0] m_addr, m_wdata, m_rdata;
   logic [N*4-1:0]  m_be;
   logic            s_req, s_gnt, s_rvalid, s_we, err;
   logic [31:0]     s_addr, s_wdata, s_rdata;
   logic [3:0]      s_be;

   always #5 clk = ~clk;

   obi_slave_arbiter #(.NUM_MASTERS(N), .MAX_OUTSTANDING(MAXO)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .m_req_i(m_req), .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid),
      .m_addr_i(m_addr), .m_we_i(m_we), .m_be_i(m_be), .m_wdata_i(m_wdata),
      .m_rdata_o(m_rdata),
      .s_req_o(s_req), .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid),
      .s_addr_o(s_addr), .s_we_o(s_we), .s_be_o(s_be), .s_wdata_o(s_wdata),
      .s_rdata_i(s_rdata), .err_o(err)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: queue of outstanding master IDs, last granted master,
   // master waiting for a grant (-1 if none), sticky error.
   int           q[$];
   int           last_gnt     = N - 1;
   int           held         = -1;
   bit           err_m        = 1'b0;
   logic [N-1:0] exp_gnt_last = '0;

   // Compare DUT against the model on every falling edge, then advance the model.
   always @(negedge clk) begin : model
      int           sel, c;
      bit           sreq, pop, full, found;
      logic [N-1:0] eg, er;
      logic [31:0]  ea, ewd;
      logic [4:0]   ewb;
      if (!rst_n) begin
         q.delete();
         last_gnt     = N - 1;
         held         = -1;
         err_m        = 1'b0;
         exp_gnt_last = '0;
      end else begin
         pop   = s_rvalid && (q.size() > 0);
         full  = (q.size() == MAXO) && !pop;
         sreq  = (m_req != '0) && !full;
         sel   = 0;
         found = 1'b0;
         if (held >= 0 && m_req[held]) begin
            sel   = held;
            found = 1'b1;
         end
         for (int k = 1; k <= N; k++) begin
`ifdef OBI_ARB_FIXED_PRIO_EN
            c = k - 1;
`else
            c = (last_gnt + k) % N;
`endif
            if (!found && m_req[c]) begin
               sel   = c;
               found = 1'b1;
            end
         end
         eg = '0;
         if (sreq && s_gnt) eg[sel] = 1'b1;
         er = '0;
         if (pop) er[q[0]] = 1'b1;
         ea  = sreq ? m_addr[sel*32 +: 32] : 32'h0;
         ewd = sreq ? m_wdata[sel*32 +: 32] : 32'h0;
         ewb = sreq ? {m_we[sel], m_be[sel*4 +: 4]} : 5'h0;
         check("mdl_gnt", m_gnt, eg);
         check("mdl_rvalid", m_rvalid, er);
         check("mdl_s_req", s_req, sreq);
         check("mdl_s_addr", s_addr, ea);
         check("mdl_s_we_be", {s_we, s_be}, ewb);
         check("mdl_s_wdata", s_wdata, ewd);
         check("mdl_err", err, err_m);
         check("mdl_rdata", m_rdata, {N{s_rdata}});
         if (s_rvalid && q.size() == 0) err_m = 1'b1;
         if (pop) void'(q.pop_front());
         if (sreq && s_gnt) begin
            q.push_back(sel);
            last_gnt = sel;
            held     = -1;
         end else if (sreq) begin
            held = sel;
         end else if (held >= 0 && !m_req[held]) begin
            held = -1;
         end
         exp_gnt_last = eg;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      m_req = '0; m_we = '0; m_be = '0; m_addr = '0; m_wdata = '0;
      s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   logic [N-1:0] gnt_pat [4];

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      #2;
      check("reset_ctrl", {m_gnt, m_rvalid, s_req, s_we, s_be, err}, '0);
      check("reset_addr", s_addr, 32'h0);
      check("reset_wdata", s_wdata, 32'h0);
      step();
      step();
      rst_n = 1'b1;

      // Single master read, immediate grant, response next cycle.
      step();
      m_req = 2'b01; m_addr[31:0] = 32'h8000_0004; s_gnt = 1'b1;
      #1;
      check("t1_gnt", m_gnt, 2'b01);
      check("t1_addr", s_addr, 32'h8000_0004);
      step();
      m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF;
      #1;
      check("t1_rvalid", m_rvalid, 2'b01);
      check("t1_rdata0", m_rdata[31:0], 32'hDEAD_BEEF);
      step();
      s_rvalid = 1'b0;

      // Both masters request every cycle.
      do_reset();
`ifdef OBI_ARB_FIXED_PRIO_EN
      gnt_pat = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
      gnt_pat = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
      m_req = 2'b11; s_gnt = 1'b1;
      m_addr = {32'h0000_0200, 32'h0000_0100};
      for (int c = 0; c < 4; c++) begin
         s_rvalid = (c > 0);
         #1;
         check("t2_gnt", m_gnt, gnt_pat[c]);
         if (c > 0) check("t2_rvalid", m_rvalid, gnt_pat[c-1]);
         step();
      end
      m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b1;
      step();
      s_rvalid = 1'b0;

      // Waiting request stays locked while another master joins.
      m_req = 2'b10; m_addr = {32'h0000_0010, 32'h0000_0020}; s_gnt = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (c == 1) m_req[0] = 1'b1;
         #1;
         check("t3_addr_hold", s_addr, 32'h10);
         check("t3_no_gnt", m_gnt, 2'b00);
         step();
      end
      s_gnt = 1'b1;
      #1;
      check("t3_gnt_m1", m_gnt, 2'b10);
      check("t3_addr_m1", s_addr, 32'h10);
      step();
      m_req[1] = 1'b0;
      #1;
      check("t3_gnt_m0", m_gnt, 2'b01);
      check("t3_addr_m0", s_addr, 32'h20);
      step();

      // FIFO full blocks requests; a response in the same cycle frees a slot.
      m_req = 2'b10; m_addr[63:32] = 32'h30;
      #1;
      check("t4_full_req", s_req, 1'b0);
      check("t4_full_gnt", m_gnt, 2'b00);
      step();
      s_rvalid = 1'b1;
      #1;
      check("t4_pp_req", s_req, 1'b1);
      check("t4_pp_gnt", m_gnt, 2'b10);
      check("t4_pp_rvalid", m_rvalid, 2'b10);
      step();
      s_rvalid = 1'b0;
      #1;
      check("t4_still_full", s_req, 1'b0);
      step();
      m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b1;
      #1;
      check("t4_drain0", m_rvalid, 2'b01);
      step();
      #1;
      check("t4_drain1", m_rvalid, 2'b10);
      step();

      // Response with nothing outstanding.
      #1;
      check("t5_dropped", m_rvalid, 2'b00);
      check("t5_err_pre", err, 1'b0);
      step();
      s_rvalid = 1'b0;
      #1;
      check("t5_err_set", err, 1'b1);
      step();
      step();
      check("t5_err_sticky", err, 1'b1);

      // Asynchronous reset with two outstanding transactions.
      do_reset();
      check("t6_err_clr", err, 1'b0);
      m_req = 2'b01; s_gnt = 1'b1;
      step();
      step();
      m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b1;
      #1;
      check("t6_rvalid_pre", m_rvalid, 2'b01);
      #1;
      rst_n = 1'b0;
      #1;
      check("t6_rvalid_rst", m_rvalid, 2'b00);
      check("t6_ctrl_rst", {m_gnt, s_req, err}, '0);
      step();
      rst_n = 1'b1;
      step();
      s_rvalid = 1'b0;
      #1;
      check("t6_err_after", err, 1'b1);

      // Randomized traffic checked by the model.
      do_reset();
      for (int cyc = 0; cyc < 2000; cyc++) begin
         for (int m = 0; m < N; m++) begin
            if (!(m_req[m] && !exp_gnt_last[m])) begin
               m_req[m]           = ($urandom_range(99) < 55);
               m_addr[m*32 +: 32] = $urandom;
               m_wdata[m*32 +: 32] = $urandom;
               m_we[m]            = $urandom_range(1);
               m_be[m*4 +: 4]     = 4'($urandom_range(15));
            end
         end
         s_gnt    = ($urandom_range(99) < 70);
         s_rvalid = (q.size() > 0) ? ($urandom_range(99) < 50) : ($urandom_range(99) < 3);
         s_rdata  = $urandom;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
